button_event_queue: RTL and testbench
=====================================

Name: button_event_queue

Overview:
- Upstream feeder of the memory-mapped button read at data address 7.
- Synchronises and debounces the four raw push-buttons, then turns each debounced press into one colour event.
- Queues the events in a small FIFO so the MIPS polling loop never misses a press.
- Pops one event per processor read, using the same 2-bit colour code as the LED store path: 00 red, 01 blue, 10 green, 11 yellow.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronised input must differ from the stable level before the stable level flips (10 ms at 50 MHz); legal range is 1 or more.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clock  in  1  system clock, the 50 MHz processor clock
- reset  in  1  synchronous, active-high reset
- red_button  in  1  raw asynchronous button, high = pressed
- blue_button  in  1  raw asynchronous button
- green_button  in  1  raw asynchronous button
- yellow_button  in  1  raw asynchronous button
- rd_en  in  1  single-cycle pop strobe, asserted by the wrapper for a load from address 7
- data_out  out  32  {28'b0, overflow, valid, color[1:0]}, combinational from the FIFO head
- fifo_empty  out  1  high when no events are queued

Behaviour:
- Reset, sampled at a rising clock edge:
  - clears the synchronisers, stable levels, debounce counters, pending bits, FIFO pointers and count, and the overflow flag.
  - Outputs after reset: data_out = 0, fifo_empty = 1.
  - Reset mid-operation discards all queued and pending events.
  - A button still held when reset is released is seen as a new press after the full debounce delay.
- Synchronise: each button passes through a 2-flop synchroniser.
- Debounce, one counter per button (width clog2(DEBOUNCE_CYCLES)+1):
  - The counter increments while the synced value differs from stable, and clears to 0 when they match.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, stable flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge detect:
  - A 0-to-1 flip of stable sets that button's pending bit on the same edge.
  - Releases (1-to-0 flips) generate nothing.
- Enqueue arbiter:
  - Each cycle, if any pending bit is set and the FIFO can accept an entry, the highest-priority pending button is written and its pending bit cleared. Priority: red > blue > green > yellow.
  - At most one enqueue per cycle; simultaneous presses are therefore queued over consecutive cycles in priority order.
  - The FIFO can accept an entry when count < DEPTH, or when count == DEPTH and rd_en is asserted in the same cycle.
- Overflow:
  - A new rising edge on a button whose pending bit is already set is dropped and sets the sticky overflow flag.
  - A full FIFO only stalls pending bits; it loses nothing by itself.
- Latency:
  - Count edge 1 as the first clock edge that samples a raw button high, with the button held steady.
  - stable goes high at edge DEBOUNCE_CYCLES+2; the pending bit is set at that same edge.
  - The entry is enqueued at edge DEBOUNCE_CYCLES+3.
  - data_out[2] = 1 is visible right after edge DEBOUNCE_CYCLES+3, provided the FIFO was empty.
- Read:
  - data_out[1:0] = head colour; data_out[2] = !fifo_empty; data_out[3] = overflow.
  - When rd_en is high and the FIFO is non-empty, the head is popped at the edge.
  - When rd_en is high and the FIFO is empty, data_out = {28'b0, overflow, 3'b000} and no state changes.
  - rd_en high always clears overflow at the edge, whether or not the FIFO is empty.
  - A pop and an enqueue in the same cycle both take effect; count is unchanged.
- Pointers: the read and write pointers wrap modulo DEPTH.

Optional Feature:
- Macro: BTN_EVENT_ECHO_EN.
- When defined:
  - Adds output port led_echo, 4 bits, ordered {yellow, green, blue, red}. It is registered and equals the four debounced stable levels, so the LEDs mirror held buttons without software.
  - Resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold red_button high from edge 1 → data_out goes from 0 to 32'h4 after edge 7; a 1-cycle rd_en pops it → data_out = 0, fifo_empty = 1.
- DEBOUNCE_CYCLES=4. Pulse blue_button high for 3 cycles, then low → no event; data_out stays 0 for 50 cycles.
- DEBOUNCE_CYCLES=4. Raise red, green and yellow on the same edge → three enqueues on consecutive cycles. Successive reads return 32'h4, 32'h6, 32'h7, then 32'h0.
- DEPTH=4, no reads. Make five distinct presses (red, blue, green, yellow, red) → four entries queued and red held pending. The first read returns 32'h4 and the fifth entry enqueues that same cycle. A second red press while red is still pending → the next read shows bit 3 set, and the read after that shows it cleared.
- DEBOUNCE_CYCLES=4. Queue two events, assert reset for 1 cycle with green held → data_out = 0, fifo_empty = 1. Green then reappears as 32'h6 after the full debounce delay.
- rd_en with the FIFO empty and overflow clear → data_out = 0 and pointers unchanged; a later single press still reads back correctly.

Source files
------------

// File: rtl/button_event_queue.sv
// Debounced four-button colour event queue feeding the MIPS button read at address 7.
// Define BTN_EVENT_ECHO_EN to add the led_echo output mirroring the debounced levels.
module button_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEPTH           = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        rd_en,
    output logic [31:0] data_out,
    output logic        fifo_empty
`ifdef BTN_EVENT_ECHO_EN
    ,
    output logic [3:0]  led_echo
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    // Bit index doubles as the colour code: 0 red, 1 blue, 2 green, 3 yellow.
    logic [3:0] raw;
    assign raw = {yellow_button, green_button, blue_button, red_button};

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [3:0] rise;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       accept;
    logic       push;
    logic       pop;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    rise[i]     = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        pop        = rd_en && !fifo_empty;
        // A full FIFO still takes an entry when the same edge pops the head.
        accept     = (count_q != CNT_FULL) || rd_en;
        grant      = '0;
        grant_idx  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (accept && pending_q[i] && grant == '0) begin
                grant[i]  = 1'b1;
                grant_idx = 2'(i);
            end
        end
        push       = |grant;
        // A rise on a still-pending button is dropped rather than merged.
        pending_d  = (pending_q & ~grant) | (rise & ~pending_q);
        overflow_d = (overflow_q & ~rd_en) | (|(rise & pending_q));

        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = grant_idx;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

        data_out = {28'b0, overflow_q, !fifo_empty, fifo_empty ? 2'b00 : mem_q[rd_ptr_q]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

`ifdef BTN_EVENT_ECHO_EN
    assign led_echo = stable_q;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue: directed scenarios then random button/read traffic.
// A cycle-level reference model pushes expected outputs; a negedge monitor pops and compares.
module tb_button_event_queue;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        red_button = 1'b0, blue_button = 1'b0, green_button = 1'b0, yellow_button = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] data_out;
    logic        fifo_empty;
`ifdef BTN_EVENT_ECHO_EN
    logic [3:0]  led_echo;
`endif

    int checks = 0;
    int errors = 0;

    button_event_queue #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .red_button    (red_button),
        .blue_button   (blue_button),
        .green_button  (green_button),
        .yellow_button (yellow_button),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .fifo_empty    (fifo_empty)
`ifdef BTN_EVENT_ECHO_EN
        ,
        .led_echo      (led_echo)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        empty;
        logic [3:0]  stable;
    } exp_t;

    exp_t sb[$];

    // Reference model: buttons indexed 0 red .. 3 yellow.
    logic [3:0] m_s1, m_s2, m_stable, m_pending;
    int         m_run [4];
    logic [1:0] m_fifo[$];
    logic       m_ovf;

    function automatic logic [31:0] m_data();
        if (m_fifo.size() > 0) return {28'b0, m_ovf, 1'b1, m_fifo[0]};
        return {28'b0, m_ovf, 3'b000};
    endfunction

    task automatic model_step(input logic [3:0] b, input logic rd, input logic rst);
        logic [3:0] rise, old_pend, new_stable;
        logic       drop;
        int         g;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pending = '0; m_ovf = 1'b0;
            m_fifo.delete();
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            return;
        end
        rise = '0;
        new_stable = m_stable;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    new_stable[i] = ~m_stable[i];
                    rise[i] = ~m_stable[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        old_pend = m_pending;
        g = -1;
        if (m_fifo.size() < DEPTH || rd) begin
            for (int i = 0; i < 4; i++) if (g < 0 && old_pend[i]) g = i;
        end
        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (g >= 0) begin
            m_fifo.push_back(2'(g));
            m_pending[g] = 1'b0;
        end
        drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) begin
                if (old_pend[i]) drop = 1'b1;
                else m_pending[i] = 1'b1;
            end
        end
        m_ovf = (m_ovf && !rd) || drop;
        m_stable = new_stable;
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic tick(input logic [3:0] b, input logic rd, input logic rst);
        exp_t e;
        {yellow_button, green_button, blue_button, red_button} = b;
        rd_en = rd;
        reset = rst;
        @(posedge clock);
        model_step(b, rd, rst);
        #1;
        e.data   = m_data();
        e.empty  = (m_fifo.size() == 0);
        e.stable = m_stable;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap);
        repeat (hold) tick(b, 1'b0, 1'b0);
        repeat (gap) tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic model_expect(input string name, input logic [31:0] val);
        checks++;
        if (m_data() !== val) begin
            errors++;
            $display("FAIL %s: model data_out %h, required %h", name, m_data(), val);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || fifo_empty !== e.empty) begin
                errors++;
                $display("FAIL data_out/fifo_empty at %0t: got %h/%b, expected %h/%b",
                         $time, data_out, fifo_empty, e.data, e.empty);
            end
`ifdef BTN_EVENT_ECHO_EN
            checks++;
            if (led_echo !== e.stable) begin
                errors++;
                $display("FAIL led_echo at %0t: got %b, expected %b", $time, led_echo, e.stable);
            end
`endif
        end
    end

    initial begin
        logic [3:0] cur;
        logic       rd, rst;

        // Reset
        repeat (2) tick(4'b0000, 1'b0, 1'b1);
        model_expect("reset", 32'h0);

        // Red held: event appears after edge D+3, then one pop empties the queue
        repeat (D + 2) tick(4'b0001, 1'b0, 1'b0);
        model_expect("red_before_latency", 32'h0);
        tick(4'b0001, 1'b0, 1'b0);
        model_expect("red_latency", 32'h4);
        tick(4'b0001, 1'b1, 1'b0);
        model_expect("red_popped", 32'h0);
        press(4'b0000, 0, 12);

        // Blue glitch shorter than the debounce window
        press(4'b0010, 3, 50);
        model_expect("blue_glitch", 32'h0);

        // Simultaneous red, green, yellow
        repeat (10) tick(4'b1101, 1'b0, 1'b0);
        model_expect("simul_red", 32'h4);
        tick(4'b1101, 1'b1, 1'b0);
        model_expect("simul_green", 32'h6);
        tick(4'b1101, 1'b1, 1'b0);
        model_expect("simul_yellow", 32'h7);
        tick(4'b1101, 1'b1, 1'b0);
        model_expect("simul_drained", 32'h0);
        tick(4'b1101, 1'b1, 1'b0);
        model_expect("simul_empty_read", 32'h0);
        press(4'b0000, 0, 12);

        // Full FIFO stalls the fifth press; a repeat press while pending overflows
        press(4'b0001, 10, 10);
        press(4'b0010, 10, 10);
        press(4'b0100, 10, 10);
        press(4'b1000, 10, 10);
        press(4'b0001, 10, 10);
        model_expect("full_head", 32'h4);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("full_refill", 32'h5);
        press(4'b0001, 10, 10);
        press(4'b0001, 10, 10);
        model_expect("overflow_set", 32'hD);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("overflow_cleared", 32'h6);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("drain_yellow", 32'h7);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("drain_red_a", 32'h4);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("drain_red_b", 32'h4);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("drain_empty", 32'h0);

        // Reset mid-operation with green held
        press(4'b0001, 10, 10);
        press(4'b0010, 10, 10);
        tick(4'b0100, 1'b0, 1'b1);
        model_expect("reset_discard", 32'h0);
        repeat (D + 2) tick(4'b0100, 1'b0, 1'b0);
        model_expect("green_pending", 32'h0);
        tick(4'b0100, 1'b0, 1'b0);
        model_expect("green_after_reset", 32'h6);
        tick(4'b0000, 1'b1, 1'b0);
        press(4'b0000, 0, 12);

        // Read with empty FIFO, then a single press
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("empty_read", 32'h0);
        press(4'b0010, 10, 10);
        model_expect("single_blue", 32'h5);
        tick(4'b0000, 1'b1, 1'b0);
        model_expect("single_blue_popped", 32'h0);

        // Random traffic
        cur = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(11) == 0) cur[i] = ~cur[i];
            end
            rd  = ($urandom_range(5) == 0);
            rst = ($urandom_range(1499) == 0);
            tick(cur, rd, rst);
        end

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
